dequant_rr_scheduler: RTL and testbench

// - Shares one dequantizer_block (fixed LATENCY, no stall) among NUM_REQ requesters.
// - Round-robin arbitration with valid/ready per requester; one issue per cycle.
// - Tags each issue with the requester id in a LATENCY-deep tag pipe and routes
//   dq_weight_fp back as a registered response.
// - Run/drain FSM lets the layer sequencer quiesce the datapath between tensors.

---
 rtl/dequant_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_dequant_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dequant_rr_scheduler.sv
// Round-robin issue scheduler that shares one fixed-latency dequantizer among
// several requesters and returns each result tagged with its requester id.
module dequant_rr_scheduler #(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  LATENCY = 5,
    parameter int unsigned  DATA_W  = 32,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      drain_req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_level,
    input  logic [NUM_REQ-1:0]        req_is_weight,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         dq_level_int,
    output logic                      dq_is_weight,
    input  logic [DATA_W-1:0]         dq_weight_fp,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      drain_done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]    tag_id [LATENCY];
    logic               grant_en;
    logic               grant_found;
    logic               handshake;
    logic [ID_W-1:0]    grant_id;

    // drain_req gates grants even while the state is still RUN
    assign grant_en  = (state == RUN) && enable && !drain_req;
    assign handshake = grant_en && grant_found;
    assign busy      = (|tag_valid) || (|rsp_valid);

    // First valid lane scanning upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        dq_level_int = '0;
        dq_is_weight = 1'b0;
        if (handshake) begin
            req_ready[grant_id] = 1'b1;
            dq_level_int        = req_level[32'(grant_id) * DATA_W +: DATA_W];
            dq_is_weight        = req_is_weight[grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            tag_valid  <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                tag_id[k] <= '0;
            end
            rsp_valid  <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !drain_req) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (drain_req) begin
                        state <= DRAIN;
                    end else if (!enable && !busy) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!busy) begin
                        state      <= IDLE;
                        drain_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (handshake) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end

            // Tag pipe tracks the dequantizer latency exactly; it never stalls
            tag_valid <= {tag_valid[LATENCY-2:0], handshake};
            tag_id[0] <= grant_id;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            rsp_valid <= '0;
            if (tag_valid[LATENCY-1]) begin
                rsp_valid[tag_id[LATENCY-1]] <= 1'b1;
                rsp_id                       <= tag_id[LATENCY-1];
                rsp_data                     <= dq_weight_fp;
            end
        end
    end
endmodule

// File: tb/tb_dequant_rr_scheduler.sv
// Directed bench for dequant_rr_scheduler with a fixed-latency dequantizer stand-in.
module tb_dequant_rr_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      enable;
    logic                      drain_req;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_level;
    logic [NUM_REQ-1:0]        req_is_weight;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         dq_level_int;
    logic                      dq_is_weight;
    logic [DATA_W-1:0]         dq_weight_fp;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic                      drain_done;

    int errors = 0;
    int checks = 0;

    // Expected results for lanes 0..3 at levels 10..13, odd lanes are weights
    logic [31:0] exp_lane [4] = '{32'h3200_0000, 32'h4240_0000, 32'h3280_0000, 32'h42C0_0000};

    logic [31:0] dq_pipe [LATENCY];

    dequant_rr_scheduler #(
        .NUM_REQ(NUM_REQ),
        .LATENCY(LATENCY),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .drain_req    (drain_req),
        .req_valid    (req_valid),
        .req_level    (req_level),
        .req_is_weight(req_is_weight),
        .req_ready    (req_ready),
        .dq_level_int (dq_level_int),
        .dq_is_weight (dq_is_weight),
        .dq_weight_fp (dq_weight_fp),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fp_model(input logic [31:0] lvl, input logic w);
        return (w ? 32'h4000_0000 : 32'h3000_0000) + ((lvl - 32'd2) << 22);
    endfunction

    // Dequantizer stand-in: LATENCY-cycle pipe sharing the scheduler reset
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) dq_pipe[i] <= '0;
        end else begin
            dq_pipe[0] <= fp_model(dq_level_int, dq_is_weight);
            for (int i = 1; i < LATENCY; i++) dq_pipe[i] <= dq_pipe[i-1];
        end
    end
    assign dq_weight_fp = dq_pipe[LATENCY-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b0;
        enable        = 1'b0;
        drain_req     = 1'b0;
        req_valid     = '0;
        req_level     = {32'd13, 32'd12, 32'd11, 32'd10};
        req_is_weight = 4'b1010;
        step();
        step();
        check("rst_rsp_valid",  32'(rsp_valid),  32'h0);
        check("rst_rsp_id",     32'(rsp_id),     32'h0);
        check("rst_rsp_data",   rsp_data,        32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_drain_done", 32'(drain_done), 32'h0);
        check("rst_req_ready",  32'(req_ready),  32'h0);

        rst    = 1'b1;
        enable = 1'b1;
        step();

        // Single lane 0 request, result returns six edges later
        req_level[31:0]  = 32'd3;
        req_is_weight[0] = 1'b1;
        req_valid        = 4'b0001;
        #1;
        check("t1_ready",     32'(req_ready),    32'h1);
        check("t1_level",     dq_level_int,      32'd3);
        check("t1_is_weight", 32'(dq_is_weight), 32'h1);
        step();
        req_valid        = '0;
        req_level[31:0]  = 32'd10;
        req_is_weight[0] = 1'b0;
        check("t1_early_rsp", 32'(rsp_valid), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t1_early_rsp", 32'(rsp_valid), 32'h0);
        end
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_id",    32'(rsp_id),    32'h0);
        check("t1_rsp_data",  rsp_data,       32'h4040_0000);
        check("t1_busy",      32'(busy),      32'h1);
        step();
        check("t1_rsp_clear", 32'(rsp_valid), 32'h0);
        check("t1_rsp_hold",  rsp_data,       32'h4040_0000);
        check("t1_idle_busy", 32'(busy),      32'h0);

        // Re-reset so the rotation starts at lane 0
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // All lanes valid for eight cycles
        for (int c = 0; c < 16; c++) begin
            int r;
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                check("t2_ready", 32'(req_ready), 32'h1 << (c % 4));
                check("t2_level", dq_level_int,   32'd10 + 32'(c % 4));
            end
            step();
            r = c - 5;
            if (r >= 0 && r < 8) begin
                check("t2_rsp_valid", 32'(rsp_valid), 32'h1 << (r % 4));
                check("t2_rsp_id",    32'(rsp_id),    32'(r % 4));
                check("t2_rsp_data",  rsp_data,       exp_lane[r % 4]);
            end else begin
                check("t2_rsp_idle", 32'(rsp_valid), 32'h0);
            end
        end

        // Lanes 1 and 3 only: alternate with no idle cycle
        for (int c = 0; c < 13; c++) begin
            int r;
            req_valid = (c < 6) ? 4'b1010 : 4'b0000;
            #1;
            if (c < 6) begin
                check("t3_ready", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
            end
            step();
            r = c - 5;
            if (r >= 0 && r < 6) begin
                check("t3_rsp_id",   32'(rsp_id), (r % 2 == 0) ? 32'd1 : 32'd3);
                check("t3_rsp_data", rsp_data,    (r % 2 == 0) ? exp_lane[1] : exp_lane[3]);
            end else begin
                check("t3_rsp_idle", 32'(rsp_valid), 32'h0);
            end
        end

        // Drain with three items in flight; drain_req is dropped mid-drain
        for (int c = 0; c < 10; c++) begin
            int r;
            req_valid = 4'hF;
            drain_req = (c == 3);
            #1;
            if (c < 3) begin
                check("t4_ready", 32'(req_ready), 32'h1 << c);
            end else begin
                check("t4_drain_ready", 32'(req_ready), 32'h0);
            end
            if (c == 3) begin
                check("t4_drain_level", dq_level_int, 32'h0);
            end
            step();
            r = c - 5;
            if (r >= 0 && r < 3) begin
                check("t4_rsp_valid", 32'(rsp_valid), 32'h1 << r);
                check("t4_rsp_data",  rsp_data,       exp_lane[r]);
            end else begin
                check("t4_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            check("t4_busy",       32'(busy),       (c + 1 <= 8) ? 32'h1 : 32'h0);
            check("t4_drain_done", 32'(drain_done), (c + 1 == 10) ? 32'h1 : 32'h0);
        end
        #1;
        check("t4_idle_ready", 32'(req_ready), 32'h0);
        enable = 1'b0;
        step();
        check("t4_done_pulse", 32'(drain_done), 32'h0);
        check("t4_idle_busy",  32'(busy),       32'h0);

        // Reset with two items in flight discards them and rewinds the pointer
        enable    = 1'b1;
        req_valid = '0;
        step();
        req_valid = 4'hF;
        #1;
        check("t5_ready_a", 32'(req_ready), 32'h8);
        step();
        check("t5_ready_b", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();
        check("t5_busy_pre", 32'(busy), 32'h1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t5_rst_busy", 32'(busy),      32'h0);
        check("t5_rst_rsp",  32'(rsp_valid), 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t5_no_rsp",  32'(rsp_valid), 32'h0);
            check("t5_no_busy", 32'(busy),      32'h0);
        end
        req_valid = 4'hF;
        #1;
        check("t5_ptr_ready", 32'(req_ready), 32'h1);
        check("t5_ptr_level", dq_level_int,   32'd10);

        // enable low blocks all grants
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t6_ready",     32'(req_ready),    32'h0);
            check("t6_level",     dq_level_int,      32'h0);
            check("t6_is_weight", 32'(dq_is_weight), 32'h0);
            step();
        end
        check("t6_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
